sd_sector_dma: RTL and testbench
================================

Name: sd_sector_dma

Overview:
Sector transfer engine placed between the CPU port block and the `sd` SPI byte controller. It moves one 512-byte sector between a byte-wide sector buffer RAM and the SD card, driving the controller's `sd_signal`/`sd_cmd`/`sd_out` handshake. It handles the read data token, the write data token, the data response and the card-busy poll. This lets the AVR core issue a single start instead of running per-byte SPI loops in software.

Parameters:
TOKEN_TRIES, 4096, max 0xFF polls while waiting for the read token, and max polls in the write busy wait.
SECTOR_BYTES, 512, bytes per sector; buffer index width is 9 bits.

Ports:
clock        in   1  system clock (same domain as `sd`)
reset_n      in   1  asynchronous reset, active low
start        in   1  one-cycle start request
dir          in   1  sampled with start: 0 = card->buffer (read), 1 = buffer->card (write)
busy         out  1  high from the accepted start until done
done         out  1  one-cycle pulse at end of an operation (success or error)
err          out  2  0 ok, 1 token timeout, 2 bad token/rejected, 3 busy timeout; held until next accepted start
sd_signal    out  1  one-cycle strobe to the `sd` controller
sd_cmd       out  2  always 0 (byte transfer)
sd_out       out  8  byte to shift out
sd_din       in   8  byte received by the last transfer
sd_busy      in   1  `sd` controller busy
buf_address  out  9  sector buffer index
buf_data_o   out  8  buffer write data
buf_we       out  1  buffer write strobe, one cycle
buf_data_i   in   8  buffer read data; valid the cycle after buf_address is presented (synchronous RAM)

Behaviour:
- Async reset:
  - State returns to IDLE.
  - busy, done, sd_signal, buf_we = 0; err = 0; sd_cmd = 0; sd_out = 8'hFF; buf_address = 0; counters = 0.
  - Reset mid-transfer aborts the operation; no further strobes are issued.
- Byte transfer primitive XFER(b):
  - Cycle 0: sd_out = b, sd_signal = 1 (pulse).
  - Cycle 1: guard cycle; sd_busy is ignored.
  - Cycles 2+: wait while sd_busy = 1.
  - On the first cycle with sd_busy = 0, sd_din is valid and is consumed that cycle.
  - Minimum 3 cycles per byte.
- start while busy = 1 is ignored. On an accepted start: busy = 1, err = 0, byte index = 0, try counter = 0, dir is latched.
- Read (dir = 0):
  - RD_TOKEN: XFER(FF).
    - Result FE -> RD_DATA.
    - Result FF -> increment tries; if tries == TOKEN_TRIES then err = 1 and go to FINISH, else repeat.
    - Any other result -> err = 2, FINISH.
  - RD_DATA: XFER(FF); on completion buf_address = index, buf_data_o = sd_din, buf_we = 1 for one cycle. Index increments; after index SECTOR_BYTES-1 -> RD_CRC.
  - RD_CRC: two XFER(FF); results discarded -> FINISH.
- Write (dir = 1):
  - WR_GAP: XFER(FF).
  - WR_TOKEN: XFER(FE).
  - WR_DATA, per byte:
    - FETCH: present buf_address = index.
    - Next cycle: latch buf_data_i.
    - Then XFER(latched byte).
    - 512 bytes, index 0..511.
  - WR_CRC: two XFER(FF).
  - WR_RESP: XFER(FF); if (sd_din & 1F) != 05 then err = 2, FINISH.
  - WR_BUSY: XFER(FF) repeated until sd_din != 00 -> FINISH. After TOKEN_TRIES polls that all return 00, err = 3, FINISH.
- FINISH: done = 1 for one cycle; busy = 0 in the same cycle; state returns to IDLE.
- A new start is accepted the cycle after done.
- Index is 9 bits; it never wraps within an operation because the terminal count is checked before increment.
- buf_we is never asserted during a write operation. sd_signal is never asserted in IDLE.

Test Plan:
- Read, `sd` model returns FF,FF,FF,FE then bytes i[7:0] then 2 CRC bytes -> buffer[i] = i[7:0] for i = 0..511; exactly 512 buf_we pulses; 518 sd_signal pulses; done pulse; err = 0.
- Read with TOKEN_TRIES = 8, card always returns FF -> exactly 8 token transfers; err = 1; done pulse; no buf_we.
- Read, token byte returns 0x09 -> err = 2 after the first transfer; no buf_we.
- Write, buffer preloaded with 0xA5 ^ i; response E5; busy poll returns 00,00,FF:
  - sd_out sequence is FF, FE, 512 data bytes, FF, FF, FF, then three FF polls.
  - err = 0.
- Write, response 0x0B -> err = 2; no busy polls issued. Separately, busy poll stuck at 00 with TOKEN_TRIES = 8 -> err = 3.
- Assert reset_n low at byte 200 of a read:
  - Outputs go to reset values immediately; busy = 0.
  - After release, a new read completes normally.
  - A start pulse applied while busy = 1 produces no effect.

Source files
------------

// File: rtl/sd_sector_dma.sv
// Sector transfer engine: moves one 512-byte sector between a byte-wide buffer RAM
// and the SD SPI byte controller, handling data tokens, data response and busy poll.
module sd_sector_dma #(
  parameter int TOKEN_TRIES  = 4096,
  parameter int SECTOR_BYTES = 512
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dir,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic       sd_signal,
  output logic [1:0] sd_cmd,
  output logic [7:0] sd_out,
  input  logic [7:0] sd_din,
  input  logic       sd_busy,
  output logic [8:0] buf_address,
  output logic [7:0] buf_data_o,
  output logic       buf_we,
  input  logic [7:0] buf_data_i
);

  localparam int TW = $clog2(TOKEN_TRIES + 1);
  localparam logic [8:0]    LAST    = 9'(SECTOR_BYTES - 1);
  localparam logic [TW-1:0] TRY_MAX = TW'(TOKEN_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_SIG, S_GUARD, S_WAIT, S_FETCH, S_LATCH, S_FINISH
  } state_t;

  typedef enum logic [3:0] {
    P_RD_TOKEN, P_RD_DATA, P_RD_CRC,
    P_WR_GAP, P_WR_TOKEN, P_WR_DATA, P_WR_CRC, P_WR_RESP, P_WR_BUSY
  } phase_t;

  state_t        state, state_d;
  phase_t        phase, phase_d;
  logic [8:0]    index, index_d;
  logic [TW-1:0] tries, tries_d;
  logic [1:0]    err_d;
  logic [7:0]    sd_out_d, buf_data_d;
  logic [8:0]    buf_address_d;
  logic          buf_we_d;

  assign sd_signal = (state == S_SIG);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE) && (state != S_FINISH);
  assign sd_cmd    = 2'b00;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phase       <= P_RD_TOKEN;
      index       <= '0;
      tries       <= '0;
      err         <= 2'd0;
      sd_out      <= 8'hFF;
      buf_address <= '0;
      buf_data_o  <= '0;
      buf_we      <= 1'b0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      index       <= index_d;
      tries       <= tries_d;
      err         <= err_d;
      sd_out      <= sd_out_d;
      buf_address <= buf_address_d;
      buf_data_o  <= buf_data_d;
      buf_we      <= buf_we_d;
    end
  end

  // Each byte is SIG -> GUARD -> WAIT; the phase decides what the finished byte means.
  always_comb begin
    state_d       = state;
    phase_d       = phase;
    index_d       = index;
    tries_d       = tries;
    err_d         = err;
    sd_out_d      = sd_out;
    buf_address_d = buf_address;
    buf_data_d    = buf_data_o;
    buf_we_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SIG;
          phase_d  = dir ? P_WR_GAP : P_RD_TOKEN;
          index_d  = '0;
          tries_d  = '0;
          err_d    = 2'd0;
          sd_out_d = 8'hFF;
        end
      end
      S_SIG:    state_d = S_GUARD;
      S_GUARD:  state_d = S_WAIT;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH: begin
        sd_out_d = buf_data_i;
        state_d  = S_SIG;
      end
      S_FINISH: state_d = S_IDLE;
      S_WAIT: begin
        if (!sd_busy) begin
          state_d  = S_SIG;
          sd_out_d = 8'hFF;
          case (phase)
            P_RD_TOKEN: begin
              if (sd_din == 8'hFE) begin
                phase_d = P_RD_DATA;
              end else if (sd_din == 8'hFF) begin
                tries_d = tries + 1'b1;
                if (tries_d == TRY_MAX) begin
                  err_d   = 2'd1;
                  state_d = S_FINISH;
                end
              end else begin
                err_d   = 2'd2;
                state_d = S_FINISH;
              end
            end
            P_RD_DATA: begin
              buf_we_d      = 1'b1;
              buf_address_d = index;
              buf_data_d    = sd_din;
              if (index == LAST) begin
                phase_d = P_RD_CRC;
                index_d = '0;
              end else begin
                index_d = index + 9'd1;
              end
            end
            P_RD_CRC: begin
              if (index == 9'd1) state_d = S_FINISH;
              else               index_d = index + 9'd1;
            end
            P_WR_GAP: begin
              phase_d  = P_WR_TOKEN;
              sd_out_d = 8'hFE;
            end
            P_WR_TOKEN: begin
              phase_d       = P_WR_DATA;
              index_d       = '0;
              buf_address_d = '0;
              state_d       = S_FETCH;
            end
            P_WR_DATA: begin
              if (index == LAST) begin
                phase_d = P_WR_CRC;
                index_d = '0;
              end else begin
                index_d       = index + 9'd1;
                buf_address_d = index + 9'd1;
                state_d       = S_FETCH;
              end
            end
            P_WR_CRC: begin
              if (index == 9'd1) phase_d = P_WR_RESP;
              else               index_d = index + 9'd1;
            end
            P_WR_RESP: begin
              if ((sd_din & 8'h1F) != 8'h05) begin
                err_d   = 2'd2;
                state_d = S_FINISH;
              end else begin
                phase_d = P_WR_BUSY;
                tries_d = '0;
              end
            end
            P_WR_BUSY: begin
              if (sd_din != 8'h00) begin
                state_d = S_FINISH;
              end else begin
                tries_d = tries + 1'b1;
                if (tries_d == TRY_MAX) begin
                  err_d   = 2'd3;
                  state_d = S_FINISH;
                end
              end
            end
            default: begin
              err_d   = 2'd2;
              state_d = S_FINISH;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_sector_dma.sv
// Randomized scoreboard bench for sd_sector_dma: card and buffer RAM models surround
// the DUT while a sector-level reference model predicts bytes, buffer writes and status.
`timescale 1ns/1ps
module tb_sd_sector_dma;

  localparam int TRIES  = 8;
  localparam int NBYTES = 512;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       busy, done, sd_signal, buf_we;
  logic [1:0] err, sd_cmd;
  logic [7:0] sd_out, buf_data_o;
  logic [8:0] buf_address;
  logic [7:0] sd_din = 8'hFF;
  logic       sd_busy = 1'b0;
  logic [7:0] buf_data_i = 8'h00;

  logic [7:0]  tb_mem [NBYTES];
  logic [7:0]  card_q[$];
  logic [7:0]  exp_out_q[$];
  logic [16:0] exp_wr_q[$];
  logic [1:0]  exp_err_q[$];
  logic [1:0]  last_err = 2'd0;
  logic [16:0] wr_e;
  logic [7:0]  card_pend = 8'hFF;
  int          card_cnt = 0;
  int checks = 0, errors = 0;
  int done_seen = 0, wr_seen = 0, sig_seen = 0;
  int s0, w0;

  sd_sector_dma #(.TOKEN_TRIES(TRIES), .SECTOR_BYTES(NBYTES)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dir(dir),
    .busy(busy), .done(done), .err(err),
    .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
    .sd_din(sd_din), .sd_busy(sd_busy),
    .buf_address(buf_address), .buf_data_o(buf_data_o), .buf_we(buf_we),
    .buf_data_i(buf_data_i)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h, nothing expected", name, act);
  endtask

  function automatic logic [7:0] card_at(input int n);
    return (n < card_q.size()) ? card_q[n] : 8'hFF;
  endfunction

  // Synchronous buffer RAM: data follows the address by one clock.
  always @(posedge clock) buf_data_i <= tb_mem[buf_address];

  // Card model: one response byte per strobe, after a random busy time.
  always @(negedge clock) begin
    if (!reset_n) begin
      sd_busy  = 1'b0;
      card_cnt = 0;
    end else if (sd_signal) begin
      sd_busy   = 1'b1;
      card_cnt  = $urandom_range(0, 2);
      card_pend = (card_q.size() > 0) ? card_q.pop_front() : 8'hFF;
      sd_din    = 8'($urandom);
    end else if (sd_busy) begin
      if (card_cnt == 0) begin
        sd_busy = 1'b0;
        sd_din  = card_pend;
      end else begin
        card_cnt--;
      end
    end
  end

  // Monitor: pops predictions whenever the DUT strobes, writes or finishes.
  always @(negedge clock) begin
    if (reset_n) begin
      if (sd_signal) begin
        sig_seen++;
        if (exp_out_q.size() == 0) fail_now("sd_signal_unexpected", 32'(sd_out));
        else check("sd_out", 32'(sd_out), 32'(exp_out_q.pop_front()));
        check("sd_cmd", 32'(sd_cmd), 32'd0);
      end
      if (buf_we) begin
        wr_seen++;
        tb_mem[buf_address] = buf_data_o;
        if (exp_wr_q.size() == 0) fail_now("buf_we_unexpected", 32'(buf_address));
        else begin
          wr_e = exp_wr_q.pop_front();
          check("buf_address", 32'(buf_address), 32'(wr_e[16:8]));
          check("buf_data", 32'(buf_data_o), 32'(wr_e[7:0]));
        end
      end
      if (done) begin
        done_seen++;
        check("busy_at_done", 32'(busy), 32'd0);
        if (exp_err_q.size() == 0) fail_now("done_unexpected", 32'(err));
        else check("err", 32'(err), 32'(exp_err_q.pop_front()));
        check("bytes_left_at_done", exp_out_q.size(), 32'd0);
        check("writes_left_at_done", exp_wr_q.size(), 32'd0);
      end
    end
  end

  task automatic model_read();
    int n = 0, tries = 0;
    bit stop = 0, got = 0;
    logic [7:0] r;
    logic [1:0] e = 2'd0;
    while (!stop) begin
      exp_out_q.push_back(8'hFF);
      r = card_at(n);
      n++;
      if (r == 8'hFE) begin
        got = 1; stop = 1;
      end else if (r == 8'hFF) begin
        tries++;
        if (tries == TRIES) begin e = 2'd1; stop = 1; end
      end else begin
        e = 2'd2; stop = 1;
      end
    end
    if (got) begin
      for (int i = 0; i < NBYTES; i++) begin
        exp_out_q.push_back(8'hFF);
        exp_wr_q.push_back({9'(i), card_at(n)});
        n++;
      end
      repeat (2) exp_out_q.push_back(8'hFF);
    end
    exp_err_q.push_back(e);
    last_err = e;
  endtask

  task automatic model_write();
    int n;
    logic [7:0] r;
    logic [1:0] e = 2'd3;
    exp_out_q.push_back(8'hFF);
    exp_out_q.push_back(8'hFE);
    for (int i = 0; i < NBYTES; i++) exp_out_q.push_back(tb_mem[i]);
    repeat (3) exp_out_q.push_back(8'hFF);
    n = 2 + NBYTES + 2;
    r = card_at(n);
    n++;
    if ((r & 8'h1F) != 8'h05) e = 2'd2;
    else begin
      for (int k = 0; k < TRIES && e == 2'd3; k++) begin
        exp_out_q.push_back(8'hFF);
        if (card_at(n) != 8'h00) e = 2'd0;
        n++;
      end
    end
    exp_err_q.push_back(e);
    last_err = e;
  endtask

  task automatic setup_read(input int lead, input bit pattern);
    card_q.delete();
    repeat (lead) card_q.push_back(8'hFF);
    card_q.push_back(8'hFE);
    for (int i = 0; i < NBYTES; i++) card_q.push_back(pattern ? 8'(i) : 8'($urandom));
    repeat (2) card_q.push_back(8'($urandom));
    model_read();
  endtask

  task automatic setup_write(input bit pattern, input logic [7:0] resp,
                             input int zeros, input logic [7:0] last_poll);
    for (int i = 0; i < NBYTES; i++) tb_mem[i] = pattern ? (8'hA5 ^ 8'(i)) : 8'($urandom);
    card_q.delete();
    repeat (2) card_q.push_back(8'hFF);
    repeat (NBYTES + 2) card_q.push_back(8'($urandom));
    card_q.push_back(resp);
    repeat (zeros) card_q.push_back(8'h00);
    card_q.push_back(last_poll);
    model_write();
  endtask

  task automatic applyStimulus(input logic d);
    @(negedge clock);
    start = 1'b1;
    dir   = d;
    @(negedge clock);
    start = 1'b0;
    dir   = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic checkOutput(input string name);
    int d0 = done_seen;
    int n = 0;
    while (done_seen == d0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done_pulses"}, done_seen - d0, 32'd1);
    @(negedge clock);
    check({name, "_done_low"}, 32'(done), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_err_held"}, 32'(err), 32'(last_err));
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (wr_seen < target && n < 10000) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(wr_seen >= target), 32'd1);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < NBYTES; i++) tb_mem[i] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sd_signal", 32'(sd_signal), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sd_out", 32'(sd_out), 32'hFF);
    check("rst_buf_address", 32'(buf_address), 32'd0);
    reset_n = 1'b1;

    $display("[TB] read with index pattern and three leading FF tokens");
    setup_read(3, 1'b1);
    s0 = sig_seen; w0 = wr_seen;
    applyStimulus(1'b0);
    checkOutput("read_pattern");
    check("read_pattern_strobes", sig_seen - s0, 32'd518);
    check("read_pattern_writes", wr_seen - w0, 32'd512);
    bad = 0;
    for (int i = 0; i < NBYTES; i++) if (tb_mem[i] !== 8'(i)) bad++;
    check("read_pattern_buffer_errors", bad, 32'd0);

    for (int k = 0; k < 3; k++) begin
      $display("[TB] random read %0d", k);
      setup_read($urandom_range(0, TRIES - 1), 1'b0);
      applyStimulus(1'b0);
      checkOutput("read_random");
    end

    $display("[TB] read token timeout");
    card_q.delete();
    model_read();
    s0 = sig_seen; w0 = wr_seen;
    applyStimulus(1'b0);
    checkOutput("read_timeout");
    check("read_timeout_strobes", sig_seen - s0, 32'(TRIES));
    check("read_timeout_writes", wr_seen - w0, 32'd0);

    $display("[TB] read bad token");
    card_q.delete();
    card_q.push_back(8'h09);
    model_read();
    s0 = sig_seen;
    applyStimulus(1'b0);
    checkOutput("read_bad_token");
    check("read_bad_token_strobes", sig_seen - s0, 32'd1);

    $display("[TB] write A5^i, response E5, two busy polls");
    setup_write(1'b1, 8'hE5, 2, 8'hFF);
    s0 = sig_seen; w0 = wr_seen;
    applyStimulus(1'b1);
    checkOutput("write_pattern");
    check("write_pattern_strobes", sig_seen - s0, 32'd520);
    check("write_pattern_writes", wr_seen - w0, 32'd0);

    for (int k = 0; k < 2; k++) begin
      $display("[TB] random write %0d", k);
      setup_write(1'b0, {3'($urandom), 5'h05}, $urandom_range(0, TRIES - 1),
                  8'($urandom_range(1, 255)));
      applyStimulus(1'b1);
      checkOutput("write_random");
    end

    $display("[TB] write rejected");
    setup_write(1'b0, 8'h0B, 0, 8'hFF);
    s0 = sig_seen;
    applyStimulus(1'b1);
    checkOutput("write_rejected");
    check("write_rejected_strobes", sig_seen - s0, 32'd517);

    $display("[TB] write busy stuck");
    setup_write(1'b0, 8'h05, TRIES + 2, 8'h00);
    applyStimulus(1'b1);
    checkOutput("write_busy_stuck");

    $display("[TB] reset during read, start ignored while busy");
    setup_read(1, 1'b0);
    w0 = wr_seen;
    applyStimulus(1'b0);
    wait_writes(w0 + 50, "reached_byte_50");
    @(negedge clock);
    start = 1'b1;
    dir   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dir   = 1'b0;
    wait_writes(w0 + 200, "reached_byte_200");
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sd_signal", 32'(sd_signal), 32'd0);
    check("abort_buf_we", 32'(buf_we), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_sd_out", 32'(sd_out), 32'hFF);
    check("abort_buf_address", 32'(buf_address), 32'd0);
    check("abort_writes", wr_seen - w0 <= 201, 32'd1);
    exp_out_q.delete();
    exp_wr_q.delete();
    exp_err_q.delete();
    card_q.delete();
    repeat (3) @(negedge clock);
    s0 = sig_seen;
    check("abort_no_strobes", sig_seen - s0, 32'd0);
    reset_n = 1'b1;

    $display("[TB] read after reset");
    setup_read(2, 1'b0);
    applyStimulus(1'b0);
    checkOutput("read_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
